// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock access controller and its key strobe front end.
package lock_pkg;

  localparam int KEY_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  function automatic logic is_onehot4(input logic [KEY_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - KEY_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_edge_strobe.sv
// Turns debounced key levels into a single-cycle one-hot strobe on a fresh press.
// Reusable by any keypad consumer; i_enable gates forwarding without disturbing edge tracking.
module key_edge_strobe
  import lock_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [KEY_WIDTH-1:0] i_key_in,
  input  logic                 i_enable,
  output logic [KEY_WIDTH-1:0] o_key_out,
  output logic                 o_press
);

  logic [KEY_WIDTH-1:0] r_key_prev;
  logic [KEY_WIDTH-1:0] r_key_out;
  logic                 w_press;

  assign w_press = (r_key_prev == '0) && is_onehot4(i_key_in) && i_enable;

  always_ff @(posedge i_clock) begin
    // key_prev tracks the pad even under reset, so a key held through reset is never a press
    r_key_prev <= i_key_in;
    if (i_reset) begin
      r_key_out <= '0;
    end else begin
      r_key_out <= w_press ? i_key_in : '0;
    end
  end

  assign o_key_out = r_key_out;
  assign o_press   = w_press;

endmodule

// File: rtl/lock_access_controller.sv
// Gatekeeper between keypad and digital lock: forwards key strobes, counts failures,
// and blocks keys for a hold-off after each failure or a long lockout after MAX_FAILS.
//   state      | meaning
//   ST_IDLE    | keys forwarded, watching lock error/locked edges
//   ST_HOLDOFF | short key block after a failure
//   ST_LOCKOUT | long key block after MAX_FAILS consecutive failures
module lock_access_controller
  import lock_pkg::*;
#(
  parameter int PASSCODE_LENGTH = 3,
  parameter int CLOCK_FREQ      = 50000000,
  parameter int MAX_FAILS       = 3,
  parameter int HOLDOFF_CYCLES  = CLOCK_FREQ / 2,
  parameter int LOCKOUT_CYCLES  = CLOCK_FREQ * 30,
  localparam int FC_W = $clog2(MAX_FAILS + 1),
  localparam int DC_W = $clog2(PASSCODE_LENGTH + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [KEY_WIDTH-1:0] i_key_in,
  input  logic                 i_lock_locked,
  input  logic                 i_lock_error,
  output logic [KEY_WIDTH-1:0] o_key_out,
  output logic                 o_lockout,
  output logic                 o_holdoff,
  output logic [FC_W-1:0]      o_fail_count,
  output logic [DC_W-1:0]      o_digit_count
);

  localparam int TMR_MAX = (HOLDOFF_CYCLES > LOCKOUT_CYCLES) ? HOLDOFF_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [FC_W-1:0]   r_fail_count;
  logic [FC_W-1:0]   w_fail_nxt;
  logic [DC_W-1:0]   r_digit_count;
  logic [DC_W-1:0]   w_digit_nxt;
  logic              r_err_prev;
  logic              r_locked_prev;
  logic              r_holdoff;
  logic              r_lockout;
  logic              w_fail_ev;
  logic              w_succ_ev;
  logic              w_strobe_en;
  logic              w_press;

  assign w_fail_ev   = i_lock_error && !r_err_prev;
  assign w_succ_ev   = (i_lock_locked != r_locked_prev) && !i_lock_error;
  // a failure in the same cycle as a press wins, so the press is dropped
  assign w_strobe_en = (r_state == ST_IDLE) && !w_fail_ev;

  key_edge_strobe u_key_strobe (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_key_in  (i_key_in),
    .i_enable  (w_strobe_en),
    .o_key_out (o_key_out),
    .o_press   (w_press)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_fail_nxt  = r_fail_count;
    w_digit_nxt = r_digit_count;
    if (w_succ_ev) begin
      w_fail_nxt = '0;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_fail_ev) begin
          w_digit_nxt = '0;
          if (int'(r_fail_count) + 1 < MAX_FAILS) begin
            w_fail_nxt  = r_fail_count + FC_W'(1);
            w_timer_nxt = TMR_W'(HOLDOFF_CYCLES - 1);
            w_state_nxt = ST_HOLDOFF;
          end else begin
            w_fail_nxt  = FC_W'(MAX_FAILS);
            w_timer_nxt = TMR_W'(LOCKOUT_CYCLES - 1);
            w_state_nxt = ST_LOCKOUT;
          end
        end else if (w_press) begin
          if (int'(r_digit_count) + 1 >= PASSCODE_LENGTH) begin
            w_digit_nxt = '0;
          end else begin
            w_digit_nxt = r_digit_count + DC_W'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_IDLE;
          w_fail_nxt  = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_fail_count  <= '0;
      r_digit_count <= '0;
      r_err_prev    <= 1'b0;
      r_locked_prev <= 1'b0;
      r_holdoff     <= 1'b0;
      r_lockout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_fail_count  <= w_fail_nxt;
      r_digit_count <= w_digit_nxt;
      r_err_prev    <= i_lock_error;
      r_locked_prev <= i_lock_locked;
      r_holdoff     <= (w_state_nxt == ST_HOLDOFF);
      r_lockout     <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign o_lockout     = r_lockout;
  assign o_holdoff     = r_holdoff;
  assign o_fail_count  = r_fail_count;
  assign o_digit_count = r_digit_count;

endmodule

// File: tb/tb_lock_access_controller.sv
// Self-checking bench for lock_access_controller: behavioural model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_lock_access_controller;

  localparam int HOLD = 8;
  localparam int LOCK = 40;
  localparam int MAXF = 3;
  localparam int PLEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       locked;
  logic       err;
  logic [3:0] key_out;
  logic       lockout;
  logic       holdoff;
  logic [1:0] fail_count;
  logic [1:0] digit_count;

  int checks   = 0;
  int failures = 0;

  // model: mode 0 = keys pass, 1 = short block, 2 = long block
  int         m_mode;
  int         m_left;
  int         m_fails;
  int         m_digits;
  logic [3:0] m_key;
  logic [3:0] m_kprev;
  logic       m_eprev;
  logic       m_lprev;

  int strobe_cnt;
  int hold_cnt;
  int lock_cnt;

  always #5 clk = ~clk;

  lock_access_controller #(
    .PASSCODE_LENGTH (PLEN),
    .MAX_FAILS       (MAXF),
    .HOLDOFF_CYCLES  (HOLD),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_key_in      (key),
    .i_lock_locked (locked),
    .i_lock_error  (err),
    .o_key_out     (key_out),
    .o_lockout     (lockout),
    .o_holdoff     (holdoff),
    .o_fail_count  (fail_count),
    .o_digit_count (digit_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit press;
    bit fev;
    bit sev;
    if (rst) begin
      m_mode = 0; m_left = 0; m_fails = 0; m_digits = 0; m_key = '0;
      m_kprev = key; m_eprev = 1'b0; m_lprev = 1'b0;
      return;
    end
    press = (m_kprev == 4'd0) && $onehot(key);
    fev   = err && !m_eprev;
    sev   = (locked != m_lprev) && !err;
    m_key = '0;
    if (m_mode == 0) begin
      if (fev) begin
        m_fails  = m_fails + 1;
        m_digits = 0;
        if (m_fails >= MAXF) begin
          m_mode = 2; m_left = LOCK;
        end else begin
          m_mode = 1; m_left = HOLD;
        end
      end else if (press) begin
        m_key    = key;
        m_digits = (m_digits + 1) % PLEN;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_mode == 2) m_fails = 0;
        m_mode = 0;
      end
    end
    if (sev) m_fails = 0;
    m_kprev = key;
    m_eprev = err;
    m_lprev = locked;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("key_out",     int'(key_out),     int'(m_key));
    check("holdoff",     int'(holdoff),     (m_mode == 1) ? 1 : 0);
    check("lockout",     int'(lockout),     (m_mode == 2) ? 1 : 0);
    check("fail_count",  int'(fail_count),  m_fails);
    check("digit_count", int'(digit_count), m_digits);
    if (key_out != '0) strobe_cnt++;
    if (holdoff) hold_cnt++;
    if (lockout) lock_cnt++;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fail_pulse();
    err = 1'b1;
    tick();
    err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key = '0; locked = 1'b0; err = 1'b0;
    strobe_cnt = 0; hold_cnt = 0; lock_cnt = 0;
    cyc(2);
    rst = 1'b0;
    tick();
    check("rst_key_out", int'(key_out), 0);
    check("rst_lockout", int'(lockout), 0);
    check("rst_holdoff", int'(holdoff), 0);
    check("rst_fail", int'(fail_count), 0);
    check("rst_digit", int'(digit_count), 0);

    // single press held 5 cycles
    strobe_cnt = 0;
    key = 4'b0010;
    tick();
    check("press_strobe", int'(key_out), 2);
    check("press_digit", int'(digit_count), 1);
    cyc(4);
    check("held_one_strobe", strobe_cnt, 1);
    key = '0; tick();
    key = 4'b0010; tick();
    check("repress_strobe", int'(key_out), 2);
    check("repress_digit", int'(digit_count), 2);
    key = '0; tick();
    key = 4'b0100; tick();
    check("digit_wrap", int'(digit_count), 0);
    key = '0; tick();

    // multi-bit press and key held through reset
    strobe_cnt = 0;
    key = 4'b0110; cyc(2);
    key = '0; tick();
    key = 4'b0001;
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(3);
    check("no_strobe_multi_or_held", strobe_cnt, 0);
    check("digit_stays_0", int'(digit_count), 0);
    key = '0; tick();

    // one failure: holdoff window, presses blocked
    hold_cnt = 0; strobe_cnt = 0;
    fail_pulse();
    check("hold_enter", int'(holdoff), 1);
    check("hold_fail1", int'(fail_count), 1);
    for (int i = 0; i < 12; i++) begin
      key = (i < 6 && (i % 2) == 0) ? 4'b1000 : 4'b0000;
      tick();
    end
    check("hold_len", hold_cnt, HOLD);
    check("hold_blocked", strobe_cnt, 0);
    key = 4'b0100; tick();
    check("after_hold_press", int'(key_out), 4);
    key = '0; tick();

    // three failures -> lockout
    do_reset();
    tick();
    fail_pulse(); cyc(10);
    fail_pulse(); cyc(10);
    lock_cnt = 0; strobe_cnt = 0;
    fail_pulse();
    check("lock_enter", int'(lockout), 1);
    check("lock_fail3", int'(fail_count), 3);
    for (int i = 0; i < 45; i++) begin
      key = (i < 38 && (i % 2) == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    check("lock_len", lock_cnt, LOCK);
    check("lock_blocked", strobe_cnt, 0);
    check("lock_exit_fail0", int'(fail_count), 0);
    check("lock_exit_flag", int'(lockout), 0);

    // success clears consecutive failures
    do_reset();
    tick();
    fail_pulse(); cyc(10);
    fail_pulse(); cyc(10);
    check("two_fails", int'(fail_count), 2);
    locked = 1'b1; tick();
    check("succ_clears", int'(fail_count), 0);
    fail_pulse();
    check("succ_then_hold", int'(holdoff), 1);
    check("succ_then_no_lock", int'(lockout), 0);
    check("succ_then_fail1", int'(fail_count), 1);
    cyc(10);

    // reset in the middle of lockout
    do_reset();
    tick();
    fail_pulse(); cyc(10);
    fail_pulse(); cyc(10);
    fail_pulse();
    cyc(19);
    check("mid_lock_active", int'(lockout), 1);
    do_reset();
    check("rst_lock_clear", int'(lockout), 0);
    check("rst_lock_fail0", int'(fail_count), 0);
    key = 4'b0010; tick();
    check("rst_lock_press", int'(key_out), 2);
    key = '0; tick();

    // failure and press in the same cycle
    err = 1'b1; key = 4'b0001; tick();
    check("simul_no_strobe", int'(key_out), 0);
    check("simul_holdoff", int'(holdoff), 1);
    err = 1'b0; key = '0;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
